// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect kill of an in-flight miss,
// halt, and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        pc_WEN,
    input  logic        ifid_stall,
    input  logic        ifid_flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic [1:0]  fetch_state
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        KILL   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic [XLEN-1:0]   kill_target, kill_target_n;
    logic [XLEN-1:0]   pc_plus4;
    logic              accept;

    assign pc_plus4    = pc + XLEN'(4);
    assign imemaddr    = pc;
    assign imemREN     = (state != HALTED);
    assign fetch_state = state;

    // State, PC and kill target registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            kill_target <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            kill_target <= kill_target_n;
        end
    end

    // Next-state and PC selection; halt wins over redirect and accept
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        kill_target_n = kill_target;
        accept        = 1'b0;
        case (state)
            FETCH: begin
                if (halt) begin
                    state_n = HALTED;
                end else if (redirect_en) begin
                    if (ihit) begin
                        pc_n = redirect_pc;
                    end else begin
                        // Keep the outstanding address stable until the miss returns
                        kill_target_n = redirect_pc;
                        state_n       = KILL;
                    end
                end else if (ihit && pc_WEN) begin
                    accept = 1'b1;
                    pc_n   = pc_plus4;
                end
            end
            KILL: begin
                if (halt) begin
                    state_n = HALTED;
                end else if (ihit) begin
                    pc_n    = redirect_en ? redirect_pc : kill_target;
                    state_n = FETCH;
                end else if (redirect_en) begin
                    kill_target_n = redirect_pc;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // IF/ID register: flush > stall > load (bubble unless accepted)
    always_ff @(posedge CLK) begin
        if (RST || ifid_flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_npc   <= '0;
        end else if (!ifid_stall) begin
            if (accept) begin
                ifid_valid <= 1'b1;
                ifid_instr <= imemload;
                ifid_pc    <= pc;
                ifid_npc   <= pc_plus4;
            end else begin
                ifid_valid <= 1'b0;
                ifid_instr <= '0;
                ifid_pc    <= '0;
                ifid_npc   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequencing, kill, stall/flush, pc_WEN, halt, wrap.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pc_WEN;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;
    logic [1:0]  fetch_state;

    int total = 0;
    int bad   = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .imemload    (imemload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .pc_WEN      (pc_WEN),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_npc    (ifid_npc),
        .fetch_state (fetch_state)
    );

    always #5 CLK = ~CLK;

    // Outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit        = 1'b0;
        imemload    = 32'h0;
        pc_WEN      = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    // Accept n sequential words starting from the current PC
    task automatic advance(input int n);
        idle_inputs();
        ihit   = 1'b1;
        pc_WEN = 1'b1;
        for (int i = 0; i < n; i++) step();
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (fetch_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", fetch_state); end
        total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", imemaddr); end
        total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL reset_ren got=%b exp=1", imemREN); end
        total++; if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== 97'h0) begin bad++; $display("FAIL reset_ifid valid=%b instr=%h pc=%h npc=%h exp=0", ifid_valid, ifid_instr, ifid_pc, ifid_npc); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        ihit   = 1'b1;
        pc_WEN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc   = 32'(i * 4);
            imemload = 32'hA000_0000 + 32'(i);
            step();
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, ifid_valid); end
            total++; if (ifid_pc !== exp_pc) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, ifid_pc, exp_pc); end
            total++; if (ifid_npc !== exp_pc + 32'd4) begin bad++; $display("FAIL seq_npc[%0d] got=%h exp=%h", i, ifid_npc, exp_pc + 32'd4); end
            total++; if (ifid_instr !== 32'hA000_0000 + 32'(i)) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, ifid_instr, 32'hA000_0000 + 32'(i)); end
            total++; if (imemaddr !== exp_pc + 32'd4) begin bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imemaddr, exp_pc + 32'd4); end
        end
        idle_inputs();
    endtask

    task automatic test_redirect_miss();
        do_reset();
        advance(4);
        total++; if (imemaddr !== 32'h10) begin bad++; $display("FAIL rm_start got=%h exp=00000010", imemaddr); end
        redirect_en = 1'b1;
        redirect_pc = 32'h80;
        step();
        total++; if (fetch_state !== 2'd1) begin bad++; $display("FAIL rm_kill_state got=%0d exp=1", fetch_state); end
        total++; if (imemaddr !== 32'h10) begin bad++; $display("FAIL rm_kill_addr got=%h exp=00000010", imemaddr); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rm_kill_valid got=%b exp=0", ifid_valid); end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (fetch_state !== 2'd1 || imemaddr !== 32'h10 || imemREN !== 1'b1) begin bad++; $display("FAIL rm_miss[%0d] state=%0d addr=%h ren=%b exp=1/00000010/1", i, fetch_state, imemaddr, imemREN); end
        end
        ihit     = 1'b1;
        pc_WEN   = 1'b1;
        imemload = 32'hBAD0_0000;
        step();
        total++; if (fetch_state !== 2'd0) begin bad++; $display("FAIL rm_exit_state got=%0d exp=0", fetch_state); end
        total++; if (imemaddr !== 32'h80) begin bad++; $display("FAIL rm_exit_addr got=%h exp=00000080", imemaddr); end
        total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin bad++; $display("FAIL rm_exit_ifid valid=%b instr=%h exp=0/0", ifid_valid, ifid_instr); end
        idle_inputs();
    endtask

    task automatic test_kill_overwrite();
        do_reset();
        advance(1);
        redirect_en = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h400;
        step();
        total++; if (fetch_state !== 2'd1 || imemaddr !== 32'h4) begin bad++; $display("FAIL ko_hold state=%0d addr=%h exp=1/00000004", fetch_state, imemaddr); end
        idle_inputs();
        ihit = 1'b1;
        step();
        total++; if (fetch_state !== 2'd0 || imemaddr !== 32'h400) begin bad++; $display("FAIL ko_target state=%0d addr=%h exp=0/00000400", fetch_state, imemaddr); end
        idle_inputs();
        redirect_en = 1'b1;
        redirect_pc = 32'h500;
        step();
        ihit        = 1'b1;
        redirect_pc = 32'h600;
        step();
        total++; if (fetch_state !== 2'd0 || imemaddr !== 32'h600) begin bad++; $display("FAIL ko_late_redirect state=%0d addr=%h exp=0/00000600", fetch_state, imemaddr); end
        idle_inputs();
    endtask

    task automatic test_stall_flush();
        do_reset();
        ihit        = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h80;
        step();
        idle_inputs();
        ihit     = 1'b1;
        pc_WEN   = 1'b1;
        imemload = 32'h2000_0001;
        step();
        total++; if (ifid_instr !== 32'h2000_0001 || ifid_pc !== 32'h80 || ifid_npc !== 32'h84) begin bad++; $display("FAIL sf_load instr=%h pc=%h npc=%h exp=20000001/00000080/00000084", ifid_instr, ifid_pc, ifid_npc); end
        pc_WEN     = 1'b0;
        ifid_stall = 1'b1;
        imemload   = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h2000_0001 || ifid_pc !== 32'h80) begin bad++; $display("FAIL sf_stall[%0d] valid=%b instr=%h pc=%h exp=1/20000001/00000080", i, ifid_valid, ifid_instr, ifid_pc); end
        end
        ifid_flush = 1'b1;
        step();
        total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0 || ifid_npc !== 32'h0) begin bad++; $display("FAIL sf_flush valid=%b instr=%h pc=%h npc=%h exp=0", ifid_valid, ifid_instr, ifid_pc, ifid_npc); end
        total++; if (imemaddr !== 32'h84) begin bad++; $display("FAIL sf_addr got=%h exp=00000084", imemaddr); end
        idle_inputs();
    endtask

    task automatic test_pc_wen();
        do_reset();
        advance(8);
        ihit     = 1'b1;
        pc_WEN   = 1'b0;
        imemload = 32'h1111_2222;
        step();
        total++; if (imemaddr !== 32'h20 || ifid_valid !== 1'b0) begin bad++; $display("FAIL pw_hold addr=%h valid=%b exp=00000020/0", imemaddr, ifid_valid); end
        pc_WEN = 1'b1;
        step();
        total++; if (ifid_pc !== 32'h20 || ifid_valid !== 1'b1 || ifid_instr !== 32'h1111_2222) begin bad++; $display("FAIL pw_load pc=%h valid=%b instr=%h exp=00000020/1/11112222", ifid_pc, ifid_valid, ifid_instr); end
        total++; if (imemaddr !== 32'h24) begin bad++; $display("FAIL pw_addr got=%h exp=00000024", imemaddr); end
        pc_WEN      = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        step();
        total++; if (imemaddr !== 32'h200 || ifid_valid !== 1'b0 || fetch_state !== 2'd0) begin bad++; $display("FAIL pw_redirect addr=%h valid=%b state=%0d exp=00000200/0/0", imemaddr, ifid_valid, fetch_state); end
        idle_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        ihit     = 1'b1;
        pc_WEN   = 1'b1;
        halt     = 1'b1;
        imemload = 32'h3333_3333;
        step();
        total++; if (fetch_state !== 2'd2 || imemaddr !== 32'h0 || ifid_valid !== 1'b0) begin bad++; $display("FAIL h_fetch state=%0d addr=%h valid=%b exp=2/00000000/0", fetch_state, imemaddr, ifid_valid); end
        do_reset();
        advance(2);
        redirect_en = 1'b1;
        redirect_pc = 32'h700;
        step();
        total++; if (fetch_state !== 2'd1) begin bad++; $display("FAIL h_kill_entry got=%0d exp=1", fetch_state); end
        ihit = 1'b1;
        halt = 1'b1;
        step();
        total++; if (fetch_state !== 2'd2 || imemREN !== 1'b0 || imemaddr !== 32'h8) begin bad++; $display("FAIL h_kill state=%0d ren=%b addr=%h exp=2/0/00000008", fetch_state, imemREN, imemaddr); end
        halt   = 1'b0;
        pc_WEN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (fetch_state !== 2'd2 || imemaddr !== 32'h8 || ifid_valid !== 1'b0) begin bad++; $display("FAIL h_stay[%0d] state=%0d addr=%h valid=%b exp=2/00000008/0", i, fetch_state, imemaddr, ifid_valid); end
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        total++; if (fetch_state !== 2'd0 || imemaddr !== 32'h0 || imemREN !== 1'b1) begin bad++; $display("FAIL h_reset state=%0d addr=%h ren=%b exp=0/00000000/1", fetch_state, imemaddr, imemREN); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        ihit        = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        total++; if (imemaddr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL w_setup got=%h exp=fffffffc", imemaddr); end
        redirect_en = 1'b0;
        pc_WEN      = 1'b1;
        imemload    = 32'h4444_0000;
        step();
        total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL w_addr got=%h exp=00000000", imemaddr); end
        total++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_npc !== 32'h0 || ifid_valid !== 1'b1) begin bad++; $display("FAIL w_ifid pc=%h npc=%h valid=%b exp=fffffffc/00000000/1", ifid_pc, ifid_npc, ifid_valid); end
        idle_inputs();
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_redirect_miss();
        test_kill_overwrite();
        test_stall_flush();
        test_pc_wen();
        test_halt();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
